// File: rtl/npc_pc_unit.sv
// rtl/npc_pc_unit.sv - next-PC generator and fetch PC register with optional delay slot
module npc_pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC    = 32'h0000_4180,
    parameter int               DELAY_SLOT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [1:0]       redirect_sel,
    input  logic [25:0]      i26,
    input  logic [15:0]      i16,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             exc,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4,
    output logic [WIDTH-1:0] epc_out,
    output logic             pending,
    output logic             addr_err,
    output logic             slot_err
);

    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jmp_target;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] eret_target;
    logic [WIDTH-1:0] next_target;
    logic             req;
    logic             jr_misaligned;

    assign pc4         = pc + WIDTH'(4);
    assign br_target   = pc4 + {{(WIDTH-18){i16[15]}}, i16, 2'b00};
    assign jmp_target  = {pc4[WIDTH-1:28], i26, 2'b00};
    assign jr_target   = {rs_val[WIDTH-1:2], 2'b00};
    assign eret_target = {epc_in[WIDTH-1:2], 2'b00};

    // sel 3 is reserved and behaves exactly like no request at all
    assign req           = redirect_valid && (redirect_sel != 2'd3);
    assign jr_misaligned = (redirect_sel == 2'd2) && (rs_val[1:0] != 2'b00);

    always_comb begin
        next_target = '0;
        case (redirect_sel)
            2'd0:    next_target = br_target;
            2'd1:    next_target = jmp_target;
            2'd2:    next_target = jr_target;
            default: next_target = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            epc_out  <= '0;
            pending  <= 1'b0;
            target_q <= '0;
            addr_err <= 1'b0;
            slot_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            slot_err <= 1'b0;
            if (exc) begin
                pc      <= EXC_VEC;
                epc_out <= pc;
                pending <= 1'b0;
            end else if (eret) begin
                pc       <= eret_target;
                pending  <= 1'b0;
                addr_err <= (epc_in[1:0] != 2'b00);
            end else if (stall) begin
                pc <= pc;
            end else if (pending) begin
                // the delay-slot instruction may not redirect again; its request is dropped
                pc       <= target_q;
                pending  <= 1'b0;
                slot_err <= req;
            end else if (req) begin
                addr_err <= jr_misaligned;
                if (DELAY_SLOT != 0) begin
                    target_q <= next_target;
                    pending  <= 1'b1;
                    pc       <= pc4;
                end else begin
                    pc <= next_target;
                end
            end else begin
                pc <= pc4;
            end
        end
    end

endmodule

// File: tb/tb_npc_pc_unit.sv
// tb/tb_npc_pc_unit.sv - vector table plus randomized reference-model check of npc_pc_unit
module tb_npc_pc_unit;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [1:0]  sel;
        logic [25:0] i26;
        logic [15:0] i16;
        logic [31:0] rs;
        logic        exc;
        logic        eret;
        logic [31:0] ein;
    } in_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] tgt;
        logic        pend;
        logic        aerr;
        logic        serr;
    } ms_t;

    typedef struct packed {
        in_t         in;
        int          dut;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic        e_pend;
        logic        e_aerr;
        logic        e_serr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, exc, eret;
    logic [1:0]  redirect_sel;
    logic [25:0] i26;
    logic [15:0] i16;
    logic [31:0] rs_val, epc_in;
    logic [31:0] pc_a, pc4_a, epc_a, pc_b, pc4_b, epc_b;
    logic        pend_a, aerr_a, serr_a, pend_b, aerr_b, serr_b;

    int  n_tests = 0;
    int  n_fail  = 0;
    in_t cur;
    ms_t m [2];
    vec_t rows[$];

    always #5 clk = ~clk;

    npc_pc_unit #(.DELAY_SLOT(1)) dut_ds (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_sel(redirect_sel), .i26(i26), .i16(i16), .rs_val(rs_val),
        .exc(exc), .eret(eret), .epc_in(epc_in), .pc(pc_a), .pc4(pc4_a),
        .epc_out(epc_a), .pending(pend_a), .addr_err(aerr_a), .slot_err(serr_a)
    );

    npc_pc_unit #(.DELAY_SLOT(0)) dut_im (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_sel(redirect_sel), .i26(i26), .i16(i16), .rs_val(rs_val),
        .exc(exc), .eret(eret), .epc_in(epc_in), .pc(pc_b), .pc4(pc4_b),
        .epc_out(epc_b), .pending(pend_b), .addr_err(aerr_b), .slot_err(serr_b)
    );

    // Architectural rules of the PC unit, expressed with plain integer arithmetic.
    function automatic ms_t mstep(ms_t s, bit ds, in_t v);
        ms_t         n;
        logic [31:0] seq;
        logic [31:0] t;
        int          off;
        n      = s;
        n.aerr = 1'b0;
        n.serr = 1'b0;
        seq    = s.pc + 32'd4;
        off    = $signed(v.i16);
        t      = 32'd0;
        if (v.rst) begin
            n    = '0;
            n.pc = 32'h0000_3000;
        end else if (v.exc) begin
            n.pc   = 32'h0000_4180;
            n.epc  = s.pc;
            n.pend = 1'b0;
        end else if (v.eret) begin
            n.pc   = v.ein - (v.ein % 4);
            n.pend = 1'b0;
            n.aerr = (v.ein % 4) != 0;
        end else if (v.stall) begin
            n.pc = s.pc;
        end else if (s.pend) begin
            n.pc   = s.tgt;
            n.pend = 1'b0;
            n.serr = v.rv && (v.sel != 2'd3);
        end else if (v.rv && v.sel != 2'd3) begin
            if (v.sel == 2'd0)      t = seq + 32'(off * 4);
            else if (v.sel == 2'd1) t = (seq & 32'hF000_0000) | (32'(v.i26) * 4);
            else                    t = v.rs - (v.rs % 4);
            n.aerr = (v.sel == 2'd2) && ((v.rs % 4) != 0);
            if (ds) begin
                n.tgt  = t;
                n.pend = 1'b1;
                n.pc   = seq;
            end else begin
                n.pc = t;
            end
        end else begin
            n.pc = seq;
        end
        return n;
    endfunction

    function automatic in_t mk(bit r, bit st, bit rv, logic [1:0] sel, logic [25:0] a26,
                               logic [15:0] a16, logic [31:0] rs, bit ex, bit er, logic [31:0] ein);
        in_t v;
        v = '{rst: r, stall: st, rv: rv, sel: sel, i26: a26, i16: a16, rs: rs,
              exc: ex, eret: er, ein: ein};
        return v;
    endfunction

    function automatic in_t idle();
        return mk(0, 0, 0, 2'd0, 26'd0, 16'd0, 32'd0, 0, 0, 32'd0);
    endfunction

    task automatic add(in_t v, int d, logic [31:0] p, logic [31:0] e, bit pd, bit ae, bit se);
        vec_t r;
        r = '{in: v, dut: d, e_pc: p, e_epc: e, e_pend: pd, e_aerr: ae, e_serr: se};
        rows.push_back(r);
    endtask

    task automatic apply(in_t v);
        cur            = v;
        reset          = v.rst;
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_sel   = v.sel;
        i26            = v.i26;
        i16            = v.i16;
        rs_val         = v.rs;
        exc            = v.exc;
        eret           = v.eret;
        epc_in         = v.ein;
    endtask

    task automatic chk(string name, int d, logic [31:0] e_pc, logic [31:0] e_epc,
                       bit e_pend, bit e_aerr, bit e_serr);
        logic [98:0] act, exp;
        if (d == 0) act = {pc_a, pc4_a, epc_a, pend_a, aerr_a, serr_a};
        else        act = {pc_b, pc4_b, epc_b, pend_b, aerr_b, serr_b};
        exp = {e_pc, e_pc + 32'd4, e_epc, e_pend, e_aerr, e_serr};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got pc=%h pc4=%h epc=%h pend=%b aerr=%b serr=%b, want pc=%h pc4=%h epc=%h pend=%b aerr=%b serr=%b",
                     name, d, act[98:67], act[66:35], act[34:3], act[2], act[1], act[0],
                     exp[98:67], exp[66:35], exp[34:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic tick();
        m[0] = mstep(m[0], 1'b1, cur);
        m[1] = mstep(m[1], 1'b0, cur);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            chk("model", d, m[d].pc, m[d].epc, m[d].pend, m[d].aerr, m[d].serr);
    endtask

    initial begin
        m[0] = '0;
        m[1] = '0;
        apply(idle());

        // delay-slot instance: free run, branch, stall over pending, slot error,
        // exception over stall, misaligned eret, exc in delay slot, wrap, reset mid-pending
        add(mk(1,0,0,2'd0,26'd0,16'd0,32'd0,0,0,32'd0), 0, 32'h3000, 32'h0, 0, 0, 0);
        add(idle(), 0, 32'h3004, 32'h0, 0, 0, 0);
        add(idle(), 0, 32'h3008, 32'h0, 0, 0, 0);
        add(idle(), 0, 32'h300C, 32'h0, 0, 0, 0);
        add(idle(), 0, 32'h3010, 32'h0, 0, 0, 0);
        add(mk(0,0,1,2'd0,26'd0,16'hFFFC,32'd0,0,0,32'd0), 0, 32'h3014, 32'h0, 1, 0, 0);
        add(idle(), 0, 32'h3004, 32'h0, 0, 0, 0);
        add(mk(0,0,1,2'd1,26'h0000C40,16'd0,32'd0,0,0,32'd0), 0, 32'h3008, 32'h0, 1, 0, 0);
        add(mk(0,1,1,2'd2,26'd0,16'd0,32'h5000,0,0,32'd0), 0, 32'h3008, 32'h0, 1, 0, 0);
        add(mk(0,1,1,2'd2,26'd0,16'd0,32'h5000,0,0,32'd0), 0, 32'h3008, 32'h0, 1, 0, 0);
        add(mk(0,1,0,2'd0,26'd0,16'd0,32'd0,0,0,32'd0), 0, 32'h3008, 32'h0, 1, 0, 0);
        add(idle(), 0, 32'h3100, 32'h0, 0, 0, 0);
        add(idle(), 0, 32'h3104, 32'h0, 0, 0, 0);
        add(mk(0,0,1,2'd0,26'd0,16'h0010,32'd0,0,0,32'd0), 0, 32'h3108, 32'h0, 1, 0, 0);
        add(mk(0,0,1,2'd1,26'd0,16'd0,32'd0,0,0,32'd0), 0, 32'h3148, 32'h0, 0, 0, 1);
        add(idle(), 0, 32'h314C, 32'h0, 0, 0, 0);
        add(mk(0,0,1,2'd2,26'd0,16'd0,32'h3040,0,0,32'd0), 0, 32'h3150, 32'h0, 1, 0, 0);
        add(idle(), 0, 32'h3040, 32'h0, 0, 0, 0);
        add(mk(0,1,0,2'd0,26'd0,16'd0,32'd0,1,0,32'd0), 0, 32'h4180, 32'h3040, 0, 0, 0);
        add(mk(0,0,0,2'd0,26'd0,16'd0,32'd0,0,1,32'h3046), 0, 32'h3044, 32'h3040, 0, 1, 0);
        add(idle(), 0, 32'h3048, 32'h3040, 0, 0, 0);
        add(mk(0,0,1,2'd0,26'd0,16'h0000,32'd0,0,0,32'd0), 0, 32'h304C, 32'h3040, 1, 0, 0);
        add(mk(0,0,0,2'd0,26'd0,16'd0,32'd0,1,0,32'd0), 0, 32'h4180, 32'h304C, 0, 0, 0);
        add(idle(), 0, 32'h4184, 32'h304C, 0, 0, 0);
        add(mk(0,0,0,2'd0,26'd0,16'd0,32'd0,1,1,32'h100), 0, 32'h4180, 32'h4184, 0, 0, 0);
        add(mk(0,0,1,2'd2,26'd0,16'd0,32'h2002,0,0,32'd0), 0, 32'h4184, 32'h4184, 1, 1, 0);
        add(idle(), 0, 32'h2000, 32'h4184, 0, 0, 0);
        add(mk(0,0,1,2'd3,26'd7,16'd7,32'd7,0,0,32'd0), 0, 32'h2004, 32'h4184, 0, 0, 0);
        add(mk(0,0,1,2'd2,26'd0,16'd0,32'hFFFF_FFF8,0,0,32'd0), 0, 32'h2008, 32'h4184, 1, 0, 0);
        add(idle(), 0, 32'hFFFF_FFF8, 32'h4184, 0, 0, 0);
        add(idle(), 0, 32'hFFFF_FFFC, 32'h4184, 0, 0, 0);
        add(idle(), 0, 32'h0000_0000, 32'h4184, 0, 0, 0);
        add(mk(0,0,1,2'd1,26'd5,16'd0,32'd0,0,0,32'd0), 0, 32'h4, 32'h4184, 1, 0, 0);
        add(mk(1,0,0,2'd0,26'd0,16'd0,32'd0,0,0,32'd0), 0, 32'h3000, 32'h0, 0, 0, 0);
        add(idle(), 0, 32'h3004, 32'h0, 0, 0, 0);

        // immediate instance: jump, backward branch, misaligned jr, stall, exc, eret
        add(mk(1,0,0,2'd0,26'd0,16'd0,32'd0,0,0,32'd0), 1, 32'h3000, 32'h0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(idle(), 1, 32'h3000 + 32'(k * 4), 32'h0, 0, 0, 0);
        add(mk(0,0,1,2'd1,26'h0000C40,16'd0,32'd0,0,0,32'd0), 1, 32'h3100, 32'h0, 0, 0, 0);
        add(mk(0,0,1,2'd0,26'd0,16'hFFFF,32'd0,0,0,32'd0), 1, 32'h3100, 32'h0, 0, 0, 0);
        add(mk(0,0,1,2'd2,26'd0,16'd0,32'h3001,0,0,32'd0), 1, 32'h3000, 32'h0, 0, 1, 0);
        add(idle(), 1, 32'h3004, 32'h0, 0, 0, 0);
        add(mk(0,1,1,2'd1,26'd9,16'd0,32'd0,0,0,32'd0), 1, 32'h3004, 32'h0, 0, 0, 0);
        add(mk(0,0,0,2'd0,26'd0,16'd0,32'd0,1,0,32'd0), 1, 32'h4180, 32'h3004, 0, 0, 0);
        add(mk(0,0,0,2'd0,26'd0,16'd0,32'd0,0,1,32'h3008), 1, 32'h3008, 32'h3004, 0, 0, 0);

        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i].in);
            tick();
            chk($sformatf("vec%0d", i), rows[i].dut, rows[i].e_pc, rows[i].e_epc,
                rows[i].e_pend, rows[i].e_aerr, rows[i].e_serr);
        end

        for (int c = 0; c < 3000; c++) begin
            in_t v;
            v.rst   = ($urandom_range(0, 99) == 0);
            v.stall = ($urandom_range(0, 4) == 0);
            v.rv    = ($urandom_range(0, 9) < 4);
            v.sel   = 2'($urandom_range(0, 3));
            v.i26   = 26'($urandom);
            v.i16   = 16'($urandom);
            v.rs    = $urandom;
            if ($urandom_range(0, 1) == 0) v.rs[1:0] = 2'b00;
            v.exc   = ($urandom_range(0, 29) == 0);
            v.eret  = ($urandom_range(0, 29) == 0);
            v.ein   = $urandom;
            apply(v);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/npc_pc_unit.md
Name: npc_pc_unit

Overview:
- Parametrised next-PC generator plus PC register.
- Owns the fetch PC for the MIPS-style core: sequential advance, branch (16-bit offset), jump (26-bit index), jump-register, exception entry and exception return.
- Supports an optional branch delay slot and a stall hold.
- Feeds instruction memory; takes resolved redirects from decode and exception/eret controls from CP0.

Parameters:
- WIDTH, 32, PC/address width; must be ≥ 32. Jump keeps pc4[WIDTH-1:28].
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception entry address.
- DELAY_SLOT, 1, 1 = one architectural delay slot after any redirect; 0 = redirect applies immediately.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hold PC and internal state this cycle.
- redirect_valid  input  1  redirect request for the instruction at current pc.
- redirect_sel  input  2  0 = branch, 1 = jump, 2 = jr, 3 = reserved (treated as no redirect).
- i26  input  26  jump index.
- i16  input  16  branch offset in words, signed.
- rs_val  input  WIDTH  jr target.
- exc  input  1  take exception.
- eret  input  1  return from exception.
- epc_in  input  WIDTH  eret target.
- pc  output  WIDTH  current fetch PC, registered.
- pc4  output  WIDTH  pc+4, combinational.
- epc_out  output  WIDTH  pc captured on exception, registered.
- pending  output  1  delay-slot target held.
- addr_err  output  1  one-cycle pulse: jr/eret target misaligned.
- slot_err  output  1  one-cycle pulse: redirect requested while pending.

Behaviour:
- Reset values: pc = RESET_PC, epc_out = 0, pending = 0, target register = 0, addr_err = 0, slot_err = 0. Reset overrides all inputs.
- Target computation, modulo 2^WIDTH, all relative to pc4 of the redirecting instruction:
  - branch: pc4 + sign_extend(i16) << 2.
  - jump: {pc4[WIDTH-1:28], i26, 2'b00}.
  - jr: rs_val.
- Alignment: jr and eret targets load with bits [1:0] forced to 00. If the original bits [1:0] ≠ 0, addr_err pulses in the cycle after the load.
- Per-edge priority, highest first:
  1. reset.
  2. exc: pc ← EXC_VEC, epc_out ← pc, pending ← 0. Applies even when stall = 1.
  3. eret: pc ← epc_in (aligned), pending ← 0. Applies even when stall = 1.
  4. stall: all state holds; redirect_valid is ignored (upstream re-presents it).
  5. pending = 1: pc ← target register, pending ← 0. If redirect_valid = 1 in this cycle, slot_err pulses and the request is dropped.
  6. redirect_valid with a valid sel:
     - DELAY_SLOT = 1: target register ← target, pending ← 1, pc ← pc4.
     - DELAY_SLOT = 0: pc ← target.
  7. Otherwise: pc ← pc4.
- Latency:
  - Immediate mode: target appears in pc one cycle after the request.
  - Delay-slot mode: pc4 first, then the target on the following cycle (stall cycles stretch this).
- Simultaneous events:
  - exc together with eret: exc wins.
  - exc during pending: pending is discarded; epc_out = pc of the delay-slot instruction.
- Wrap-around: pc4 from 32'hFFFF_FFFC gives 0 with no flag.
- redirect_sel = 3 is treated as no redirect: sequential advance, no error.
- Reset mid-pending clears pending; the target is lost.

Test Plan:
1. Reset then free run: reset 1 cycle, no inputs → pc = 0x3000, 0x3004, 0x3008; pending = 0.
2. Branch with delay slot, DELAY_SLOT=1: at pc = 0x3010, redirect_valid, sel = 0, i16 = 0xFFFC → pc 0x3014 with pending = 1, then 0x3004 with pending = 0.
3. Jump, DELAY_SLOT=0: at pc = 0x3020, sel = 1, i26 = 0x0000C40 → next pc = 0x0000_3100.
4. Stall with pending: after a redirect, stall 3 cycles → pc and pending frozen. Then pc = target. A redirect during the stall cycles has no effect.
5. Exception over stall: pc = 0x3040, stall = 1, exc = 1 → pc = 0x4180, epc_out = 0x3040. Then eret, epc_in = 0x3046 → pc = 0x3044 and addr_err pulses once.
6. Redirect in delay slot: second redirect while pending = 1 → slot_err pulses for one cycle; pc = first target. Also check that pc4 wraps from 0xFFFF_FFFC to 0x0.
